// File: rtl/fx_dispatch_arbiter.sv
// fx_dispatch_arbiter
// Two-requester round-robin dispatcher in front of one fixed-point (FX) unit.
// Single-cycle operations can issue every cycle. The multiply opcode occupies
// the unit for MUL_LATENCY cycles, and no transfer is accepted during that time.
// flush_i aborts any occupancy and blocks acceptance for the flushed cycle.
// The arbitration pointer survives a flush.

module fx_dispatch_arbiter #(
    parameter int PAYLOAD_W   = 64,
    parameter int MUL_OPCODE  = 7,
    parameter int MUL_LATENCY = 3,
    parameter int FXUnitCode  = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 req0_valid_i,
    input  logic [0:1]           req0_unit_i,
    input  logic [0:5]           req0_opcode_i,
    input  logic [0:PAYLOAD_W-1] req0_payload_i,
    input  logic                 req1_valid_i,
    input  logic [0:1]           req1_unit_i,
    input  logic [0:5]           req1_opcode_i,
    input  logic [0:PAYLOAD_W-1] req1_payload_i,
    output logic                 req0_ready_o,
    output logic                 req1_ready_o,
    output logic                 fx_enable_o,
    output logic [0:5]           fx_opcode_o,
    output logic [0:PAYLOAD_W-1] fx_payload_o,
    output logic                 fx_src_o,
    output logic                 busy_o
);

    localparam logic [5:0] MUL_OP_C  = 6'(MUL_OPCODE);
    localparam logic [3:0] MUL_CNT_C = 4'(MUL_LATENCY - 1);
    localparam logic [1:0] UNIT_C    = 2'(FXUnitCode);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   prio_q, prio_d;
    logic                   fx_enable_q, fx_enable_d;
    logic [0:5]             fx_opcode_q, fx_opcode_d;
    logic [0:PAYLOAD_W-1]   fx_payload_q, fx_payload_d;
    logic                   fx_src_q, fx_src_d;
    logic                   busy_q, busy_d;

    logic                   elig0_s, elig1_s;
    logic                   grant_s;
    logic                   ready0_s, ready1_s;
    logic                   xfer_s;
    logic                   sel_mul_s;
    logic [0:5]             sel_opcode_s;
    logic [0:PAYLOAD_W-1]   sel_payload_s;

    // Eligibility and round-robin winner; prio_q names the favoured requester.
    always_comb begin
        elig0_s = req0_valid_i && (req0_unit_i == UNIT_C);
        elig1_s = req1_valid_i && (req1_unit_i == UNIT_C);
        if (elig0_s && elig1_s) begin
            grant_s = prio_q;
        end else if (elig1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Handshake: the winner sees ready unless occupied, flushing or in reset.
    always_comb begin
        ready0_s      = elig0_s && !grant_s && (state_q != ST_BUSY) && !flush_i && reset_i;
        ready1_s      = elig1_s &&  grant_s && (state_q != ST_BUSY) && !flush_i && reset_i;
        xfer_s        = ready0_s || ready1_s;
        sel_opcode_s  = grant_s ? req1_opcode_i  : req0_opcode_i;
        sel_payload_s = grant_s ? req1_payload_i : req0_payload_i;
        sel_mul_s     = (sel_opcode_s == MUL_OP_C);
    end

    // Next-state, occupancy counter, pointer and issue-register update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prio_d       = prio_q;
        fx_enable_d  = 1'b0;
        fx_opcode_d  = fx_opcode_q;
        fx_payload_d = fx_payload_q;
        fx_src_d     = fx_src_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    // A count of 0 here is illegal; treat it like the last cycle.
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                ST_IDLE, ST_ISSUE: begin
                    if (xfer_s) begin
                        prio_d       = ~grant_s;
                        fx_enable_d  = 1'b1;
                        fx_opcode_d  = sel_opcode_s;
                        fx_payload_d = sel_payload_s;
                        fx_src_d     = grant_s;
                        if (sel_mul_s) begin
                            state_d = ST_BUSY;
                            cnt_d   = MUL_CNT_C;
                        end else begin
                            state_d = ST_ISSUE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        busy_d = (state_d == ST_BUSY);
    end

    // State and registered outputs, cleared asynchronously by reset_i.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            prio_q       <= 1'b0;
            fx_enable_q  <= 1'b0;
            fx_opcode_q  <= 6'd0;
            fx_payload_q <= {PAYLOAD_W{1'b0}};
            fx_src_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prio_q       <= prio_d;
            fx_enable_q  <= fx_enable_d;
            fx_opcode_q  <= fx_opcode_d;
            fx_payload_q <= fx_payload_d;
            fx_src_q     <= fx_src_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready_o = ready0_s;
    assign req1_ready_o = ready1_s;
    assign fx_enable_o  = fx_enable_q;
    assign fx_opcode_o  = fx_opcode_q;
    assign fx_payload_o = fx_payload_q;
    assign fx_src_o     = fx_src_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_fx_dispatch_arbiter.sv
// Testbench for fx_dispatch_arbiter.
// The reference model tracks only the favoured requester and the number of
// edges still blocked by a multiply. Accepted issues go into a queue, and a
// negedge monitor matches them against the FX strobe.

module tb_fx_dispatch_arbiter;

    localparam int PW    = 64;
    localparam int L     = 3;
    localparam int MULOP = 7;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic          req0_valid_i, req1_valid_i;
    logic [0:1]    req0_unit_i, req1_unit_i;
    logic [0:5]    req0_opcode_i, req1_opcode_i;
    logic [0:PW-1] req0_payload_i, req1_payload_i;
    logic          req0_ready_o, req1_ready_o;
    logic          fx_enable_o;
    logic [0:5]    fx_opcode_o;
    logic [0:PW-1] fx_payload_o;
    logic          fx_src_o;
    logic          busy_o;

    typedef struct {
        logic [5:0]  op;
        logic [63:0] pl;
        logic        src;
        int          tag;
    } iss_t;

    iss_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          m_blocked;
    bit          m_prio;
    bit          mon_en = 1'b0;
    logic [5:0]  last_op;
    logic [63:0] last_pl;
    logic        last_src;

    fx_dispatch_arbiter #(
        .PAYLOAD_W  (PW),
        .MUL_OPCODE (MULOP),
        .MUL_LATENCY(L),
        .FXUnitCode (0)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .req0_valid_i  (req0_valid_i),
        .req0_unit_i   (req0_unit_i),
        .req0_opcode_i (req0_opcode_i),
        .req0_payload_i(req0_payload_i),
        .req1_valid_i  (req1_valid_i),
        .req1_unit_i   (req1_unit_i),
        .req1_opcode_i (req1_opcode_i),
        .req1_payload_i(req1_payload_i),
        .req0_ready_o  (req0_ready_o),
        .req1_ready_o  (req1_ready_o),
        .fx_enable_o   (fx_enable_o),
        .fx_opcode_o   (fx_opcode_o),
        .fx_payload_o  (fx_payload_o),
        .fx_src_o      (fx_src_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_blocked = 0;
        m_prio    = 1'b0;
        last_op   = 6'd0;
        last_pl   = 64'd0;
        last_src  = 1'b0;
    endtask

    // Check the combinational handshake and busy flag, then advance the model across the next edge.
    task automatic model_step();
        bit   e0, e1;
        int   win;
        iss_t it;
        e0 = req0_valid_i && (req0_unit_i == 2'd0);
        e1 = req1_valid_i && (req1_unit_i == 2'd0);
        chk("busy", {63'd0, busy_o}, {63'd0, (m_blocked > 0)});
        win = -1;
        if (!flush_i && m_blocked == 0) begin
            if (e0 && e1)  win = m_prio ? 1 : 0;
            else if (e0)   win = 0;
            else if (e1)   win = 1;
        end
        chk("ready0", {63'd0, req0_ready_o}, {63'd0, (win == 0)});
        chk("ready1", {63'd0, req1_ready_o}, {63'd0, (win == 1)});
        if (flush_i) begin
            m_blocked = 0;
        end else if (win >= 0) begin
            it.op  = (win == 1) ? req1_opcode_i  : req0_opcode_i;
            it.pl  = (win == 1) ? req1_payload_i : req0_payload_i;
            it.src = (win == 1);
            it.tag = cyc + 1;
            exp_q.push_back(it);
            m_prio    = (win == 0);
            m_blocked = (it.op == 6'(MULOP)) ? L - 1 : 0;
        end else if (m_blocked > 0) begin
            m_blocked--;
        end
    endtask

    task automatic drive(input logic v0, input logic [1:0] u0, input logic [5:0] op0, input logic [63:0] p0,
                         input logic v1, input logic [1:0] u1, input logic [5:0] op1, input logic [63:0] p1,
                         input logic fl);
        @(posedge clk);
        #1;
        req0_valid_i = v0; req0_unit_i = u0; req0_opcode_i = op0; req0_payload_i = p0;
        req1_valid_i = v1; req1_unit_i = u1; req1_opcode_i = op1; req1_payload_i = p1;
        flush_i = fl;
        @(negedge clk);
        model_step();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Monitor: match every FX strobe with the oldest expected issue; check that outputs hold otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   due;
            iss_t e;
            due = (exp_q.size() > 0) && (exp_q[0].tag <= cyc);
            chk("fx_enable", {63'd0, fx_enable_o}, {63'd0, due});
            if (due) begin
                e = exp_q.pop_front();
                if (fx_enable_o) begin
                    chk("fx_opcode", {58'd0, fx_opcode_o}, {58'd0, e.op});
                    chk("fx_payload", fx_payload_o, e.pl);
                    chk("fx_src", {63'd0, fx_src_o}, {63'd0, e.src});
                    chk("issue_cycle", 64'(cyc), 64'(e.tag));
                    last_op  = e.op;
                    last_pl  = e.pl;
                    last_src = e.src;
                end
            end else if (!fx_enable_o) begin
                chk("hold_opcode", {58'd0, fx_opcode_o}, {58'd0, last_op});
                chk("hold_payload", fx_payload_o, last_pl);
                chk("hold_src", {63'd0, fx_src_o}, {63'd0, last_src});
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enable"}, {63'd0, fx_enable_o}, 64'd0);
        chk({tag, "_opcode"}, {58'd0, fx_opcode_o}, 64'd0);
        chk({tag, "_payload"}, fx_payload_o, 64'd0);
        chk({tag, "_src"}, {63'd0, fx_src_o}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        chk({tag, "_ready0"}, {63'd0, req0_ready_o}, 64'd0);
        chk({tag, "_ready1"}, {63'd0, req1_ready_o}, 64'd0);
    endtask

    initial begin
        model_reset();
        reset_i = 1'b1;
        flush_i = 1'b0;
        req0_valid_i = 1'b1; req0_unit_i = 2'd0; req0_opcode_i = 6'd14; req0_payload_i = 64'h1234;
        req1_valid_i = 1'b1; req1_unit_i = 2'd0; req1_opcode_i = 6'd14; req1_payload_i = 64'h5678;
        #1 reset_i = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_clk");
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        reset_i = 1'b1;
        mon_en  = 1'b1;

        // Both requesters eligible with a single-cycle opcode: grants alternate from requester 0.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 2'd0, 6'd14, rnd64(), 1'b1, 2'd0, 6'd14, rnd64(), 1'b0);
        drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);

        // Multiply from requester 0 while requester 1 keeps waiting.
        drive(1'b1, 2'd0, 6'd7, rnd64(), 1'b1, 2'd0, 6'd14, 64'hAAAA, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b1, 2'd0, 6'd14, 64'hBBBB, 1'b0);

        // Requester 0 targets another unit, so only requester 1 transfers.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 2'd1, 6'd14, rnd64(), 1'b1, 2'd0, 6'd14, rnd64(), 1'b0);

        // Flush one cycle after a multiply transfer.
        drive(1'b1, 2'd0, 6'd7, rnd64(), 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);
        drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b1, 2'd0, 6'd14, 64'hCCCC, 1'b1);
        drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b1, 2'd0, 6'd14, 64'hCCCC, 1'b0);
        drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);

        // Reset while the multiply strobe is high and the unit is busy.
        drive(1'b1, 2'd0, 6'd7, 64'hDDDD, 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);
        drive(1'b1, 2'd0, 6'd14, 64'hEEEE, 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);
        #1 reset_i = 1'b0;
        #1 chk_all_zero("mid_busy_reset");
        model_reset();
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_unit_i = 2'd0; req1_opcode_i = 6'd21; req1_payload_i = 64'hFEED;
        reset_i = 1'b1;
        #1 model_step();
        drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic       v0, v1, fl;
            logic [1:0] u0, u1;
            logic [5:0] o0, o1;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            u0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            u1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            o0 = ($urandom_range(0, 3) == 0) ? 6'd7 : 6'($urandom_range(0, 63));
            o1 = ($urandom_range(0, 3) == 0) ? 6'd7 : 6'($urandom_range(0, 63));
            fl = ($urandom_range(0, 19) == 0);
            drive(v0, u0, o0, rnd64(), v1, u1, o1, rnd64(), fl);
        end

        for (int i = 0; i < L + 2; i++)
            drive(1'b0, 2'd0, 6'd0, 64'd0, 1'b0, 2'd0, 6'd0, 64'd0, 1'b0);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
